// File: rtl/smg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : smg_display_arbiter
//  Purpose  : Shares the six-digit seven-segment display between a background
//             value and three prioritised message sources. A granted message
//             is held for HOLD_CYCLES clocks; higher-index sources preempt,
//             lower-index sources wait in a one-deep per-source pending slot.
//  Ports    : CLK, RSTn (async, active low)
//             Idle_Data  [23:0]  background word shown when idle
//             Msg_Req    [2:0]   single-cycle request per source (bit 2 wins)
//             Msg_Data   [71:0]  source i word at [24*i+23:24*i]
//             Clear              flush active and pending messages
//             Number_Sig [23:0]  registered display word to smg_interface
//             Active_Src [1:0]   0 idle, 1..3 = source 0..2 on display
//             Busy               high while a message is held
//             Msg_Shown  [2:0]   one-cycle pulse when message i is granted
//  Options  : SMG_BLINK_EN - blink the held message against BLANK_WORD with
//             half-period BLINK_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
module smg_display_arbiter #(
    parameter int          HOLD_CYCLES  = 50_000_000,
    parameter int          BLINK_CYCLES = 12_500_000,
    parameter logic [23:0] BLANK_WORD   = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Idle_Data,
    input  logic [2:0]  Msg_Req,
    input  logic [71:0] Msg_Data,
    input  logic        Clear,
    output logic [23:0] Number_Sig,
    output logic [1:0]  Active_Src,
    output logic        Busy,
    output logic [2:0]  Msg_Shown
);

    localparam int c_CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_pend_vld, w_pend_vld_nxt;
    logic [2:0][23:0]   r_pend_data, w_pend_data_nxt;
    logic [1:0]         w_src_nxt;
    logic [2:0]         w_shown_nxt;
    logic [23:0]        w_msg_cur, w_msg_nxt, w_num_nxt;
    logic [2:0]         w_cand;
    logic               w_win_found;
    logic [1:0]         w_win;
    logic [23:0]        w_win_data;
    logic               w_grant;

    // ------------------------------------------------------------------------
    // Arbitration. The candidate set depends on the situation:
    //   idle          : any request
    //   hold, running : requests at or above the active source
    //   hold, expiry  : requests and valid pending slots, by index
    // The highest candidate is granted; every other request lands in its
    // pending slot (newest word overwrites).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_data_nxt = r_pend_data;
        w_src_nxt       = Active_Src;
        w_shown_nxt     = 3'b000;
        w_msg_nxt       = w_msg_cur;
        w_cand          = 3'b000;
        w_win_found     = 1'b0;
        w_win           = 2'd0;
        w_win_data      = 24'h000000;
        w_grant         = 1'b0;

        if (Clear) begin
            w_state_nxt    = S_IDLE;
            w_src_nxt      = 2'd0;
            w_cnt_nxt      = '0;
            w_pend_vld_nxt = 3'b000;
        end else begin
            if (r_state == S_IDLE) begin
                w_cand = Msg_Req;
            end else if (r_cnt == '0) begin
                w_cand = Msg_Req | r_pend_vld;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    w_cand[i] = Msg_Req[i] && (3'(i + 1) >= {1'b0, Active_Src});
                end
            end

            // A fresh request of a given index beats the stale slot word.
            for (int i = 0; i < 3; i++) begin
                if (w_cand[i]) begin
                    w_win_found = 1'b1;
                    w_win       = 2'(i);
                    w_win_data  = Msg_Req[i] ? Msg_Data[24*i +: 24] : r_pend_data[i];
                end
            end

            for (int i = 0; i < 3; i++) begin
                if (Msg_Req[i] && !(w_win_found && (w_win == 2'(i)))) begin
                    w_pend_vld_nxt[i]  = 1'b1;
                    w_pend_data_nxt[i] = Msg_Data[24*i +: 24];
                end
            end

            if (w_win_found) begin
                w_grant                = 1'b1;
                w_state_nxt            = S_HOLD;
                w_src_nxt              = w_win + 2'd1;
                w_cnt_nxt              = c_HOLD_LOAD;
                w_shown_nxt[w_win]     = 1'b1;
                w_msg_nxt              = w_win_data;
                w_pend_vld_nxt[w_win]  = 1'b0;
            end else if (r_state == S_HOLD) begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_src_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        end
    end

`ifdef SMG_BLINK_EN
    localparam int c_BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [c_BLK_W-1:0] c_BLINK_LOAD = c_BLK_W'(BLINK_CYCLES - 1);

    logic [c_BLK_W-1:0] r_blk_cnt, w_blk_cnt_nxt;
    logic               r_phase, w_phase_nxt;
    logic [23:0]        r_msg;

    // The display register may hold BLANK_WORD, so the message word needs
    // its own copy while blinking.
    assign w_msg_cur = r_msg;

    always_comb begin
        w_phase_nxt   = r_phase;
        w_blk_cnt_nxt = r_blk_cnt;
        if (w_grant) begin
            w_phase_nxt   = 1'b1;
            w_blk_cnt_nxt = c_BLINK_LOAD;
        end else if (w_state_nxt == S_HOLD) begin
            if (r_blk_cnt == '0) begin
                w_phase_nxt   = ~r_phase;
                w_blk_cnt_nxt = c_BLINK_LOAD;
            end else begin
                w_blk_cnt_nxt = r_blk_cnt - 1'b1;
            end
        end else begin
            w_phase_nxt   = 1'b1;
            w_blk_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_msg     <= 24'h000000;
            r_phase   <= 1'b1;
            r_blk_cnt <= '0;
        end else begin
            r_msg     <= w_msg_nxt;
            r_phase   <= w_phase_nxt;
            r_blk_cnt <= w_blk_cnt_nxt;
        end
    end

    assign w_num_nxt = (w_state_nxt == S_IDLE) ? Idle_Data
                     : (w_phase_nxt ? w_msg_nxt : BLANK_WORD);
`else
    // Without blinking the display register itself holds the message word.
    assign w_msg_cur = Number_Sig;
    assign w_num_nxt = (w_state_nxt == S_IDLE) ? Idle_Data : w_msg_nxt;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{BLANK_WORD, BLINK_CYCLES};
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pend_vld  <= 3'b000;
            r_pend_data <= '0;
            Number_Sig  <= 24'h000000;
            Active_Src  <= 2'd0;
            Busy        <= 1'b0;
            Msg_Shown   <= 3'b000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_data <= w_pend_data_nxt;
            Number_Sig  <= w_num_nxt;
            Active_Src  <= w_src_nxt;
            Busy        <= (w_state_nxt == S_HOLD);
            Msg_Shown   <= w_shown_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smg_display_arbiter
//  Purpose  : Self-checking bench for smg_display_arbiter with HOLD_CYCLES=8,
//             BLINK_CYCLES=2. A message-level model (active source, age since
//             grant, pending slots) predicts every output each cycle; directed
//             scenarios add literal expectations, then random traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smg_display_arbiter;

    localparam int          HOLD  = 8;
    localparam int          BLINK = 2;
    localparam logic [23:0] BLANK = 24'hFFFFFF;

    logic        CLK;
    logic        RSTn;
    logic [23:0] Idle_Data;
    logic [2:0]  Msg_Req;
    logic [71:0] Msg_Data;
    logic        Clear;
    logic [23:0] Number_Sig;
    logic [1:0]  Active_Src;
    logic        Busy;
    logic [2:0]  Msg_Shown;

    smg_display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK),
        .BLANK_WORD   (BLANK)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Idle_Data  (Idle_Data),
        .Msg_Req    (Msg_Req),
        .Msg_Data   (Msg_Data),
        .Clear      (Clear),
        .Number_Sig (Number_Sig),
        .Active_Src (Active_Src),
        .Busy       (Busy),
        .Msg_Shown  (Msg_Shown)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Message-level model
    // ------------------------------------------------------------------------
    int          m_src;       // 0 idle, 1..3 source 0..2
    int          m_age;       // cycles since the current grant
    logic [23:0] m_word;
    logic [23:0] m_num;
    logic [2:0]  m_shown;
    bit          m_pv [3];
    logic [23:0] m_pd [3];

    always @(posedge CLK or negedge RSTn) begin : p_model
        int win;
        bit expired;
        bit elig;
        if (!RSTn) begin
            m_src   = 0;
            m_age   = 0;
            m_word  = 24'h0;
            m_num   = 24'h0;
            m_shown = 3'b0;
            for (int i = 0; i < 3; i++) begin
                m_pv[i] = 1'b0;
                m_pd[i] = 24'h0;
            end
        end else begin
            m_shown = 3'b0;
            if (Clear) begin
                m_src = 0;
                m_age = 0;
                for (int i = 0; i < 3; i++) m_pv[i] = 1'b0;
            end else begin
                expired = (m_src != 0) && (m_age == HOLD - 1);
                win = -1;
                for (int i = 0; i < 3; i++) begin
                    if (m_src == 0)   elig = Msg_Req[i];
                    else if (expired) elig = Msg_Req[i] || m_pv[i];
                    else              elig = Msg_Req[i] && (i >= m_src - 1);
                    if (elig) win = i;
                end
                for (int i = 0; i < 3; i++) begin
                    if (Msg_Req[i] && i != win) begin
                        m_pv[i] = 1'b1;
                        m_pd[i] = Msg_Data[24*i +: 24];
                    end
                end
                if (win >= 0) begin
                    m_word       = Msg_Req[win] ? Msg_Data[24*win +: 24] : m_pd[win];
                    m_pv[win]    = 1'b0;
                    m_src        = win + 1;
                    m_age        = 0;
                    m_shown[win] = 1'b1;
                end else if (m_src != 0) begin
                    if (expired) m_src = 0;
                    else         m_age++;
                end
            end
            if (m_src == 0) m_num = Idle_Data;
`ifdef SMG_BLINK_EN
            else m_num = (((m_age / BLINK) % 2) == 0) ? m_word : BLANK;
`else
            else m_num = m_word;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_num",   32'(Number_Sig), 32'(m_num));
            chk("model_src",   32'(Active_Src), 32'(m_src));
            chk("model_busy",  32'(Busy),       (m_src != 0) ? 32'd1 : 32'd0);
            chk("model_shown", 32'(Msg_Shown),  32'(m_shown));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [71:0] dat(input int s, input logic [23:0] w);
        dat = 72'(w) << (24 * s);
    endfunction

    // Drive one request cycle; returns at the negedge after the sampling edge.
    task automatic pulse(input logic [2:0] req, input logic [71:0] d, input logic clr);
        @(negedge CLK);
        Msg_Req  = req;
        Msg_Data = d;
        Clear    = clr;
        @(negedge CLK);
        Msg_Req  = 3'b000;
        Clear    = 1'b0;
    endtask

    // Count consecutive cycles (including the current one) showing source s.
    task automatic hold_len(input int s, output int len, output int pulses);
        len    = 0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (32'(Active_Src) != 32'(s)) break;
            len++;
            if (Msg_Shown[s-1]) pulses++;
            @(negedge CLK);
        end
    endtask

    task automatic quiet_count(input int cycles, output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            if (Active_Src != 2'd0) busy_cycles++;
        end
    endtask

    int  len, pulses, nbusy;
    bit  found;

    initial begin
        RSTn      = 1'b1;
        Idle_Data = 24'h0;
        Msg_Req   = 3'b0;
        Msg_Data  = 72'h0;
        Clear     = 1'b0;
        #1 RSTn   = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_num",   32'(Number_Sig), 32'h0);
        chk("rst_src",   32'(Active_Src), 32'd0);
        chk("rst_busy",  32'(Busy),       32'd0);
        chk("rst_shown", 32'(Msg_Shown),  32'd0);

        // Background tracking
        Idle_Data = 24'h000150;
        RSTn      = 1'b1;
        @(negedge CLK);
        chk("bg_num",  32'(Number_Sig), 32'h000150);
        chk("bg_src",  32'(Active_Src), 32'd0);
        chk("bg_busy", 32'(Busy),       32'd0);

        // Single message
        pulse(3'b001, dat(0, 24'h000200), 1'b0);
        chk("single_shown", 32'(Msg_Shown),  32'b001);
        chk("single_num",   32'(Number_Sig), 32'h000200);
        chk("single_src",   32'(Active_Src), 32'd1);
        hold_len(1, len, pulses);
        chk("single_len",    32'(len),        32'd8);
        chk("single_pulses", 32'(pulses),     32'd1);
        chk("single_after",  32'(Number_Sig), 32'h000150);

        // Preemption three cycles into source 0
        repeat (2) @(negedge CLK);
        pulse(3'b001, dat(0, 24'h000200), 1'b0);
        repeat (2) @(negedge CLK);
        pulse(3'b100, dat(2, 24'hEEEEEE), 1'b0);
        chk("pre_src",   32'(Active_Src), 32'd3);
        chk("pre_num",   32'(Number_Sig), 32'hEEEEEE);
        chk("pre_shown", 32'(Msg_Shown),  32'b100);
        hold_len(3, len, pulses);
        chk("pre_len",   32'(len),        32'd8);
        chk("pre_after", 32'(Active_Src), 32'd0);
        quiet_count(10, nbusy);
        chk("pre_no_resume", 32'(nbusy), 32'd0);

        // Queueing with last writer wins
        pulse(3'b100, dat(2, 24'hAAAAAA), 1'b0);
        @(negedge CLK);
        pulse(3'b010, dat(1, 24'h000050), 1'b0);
        @(negedge CLK);
        pulse(3'b010, dat(1, 24'h000060), 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (Active_Src == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("q_reached", 32'(found),      32'd1);
        chk("q_num",     32'(Number_Sig), 32'h000060);
        hold_len(2, len, pulses);
        chk("q_len",     32'(len),        32'd8);
        chk("q_pulses",  32'(pulses),     32'd1);
        chk("q_after",   32'(Active_Src), 32'd0);

        // Clear beats a same-cycle request and flushes pending
        pulse(3'b100, dat(2, 24'h111111), 1'b0);
        pulse(3'b001, dat(0, 24'h222222), 1'b0);
        pulse(3'b100, dat(2, 24'h333333), 1'b1);
        chk("clr_src",   32'(Active_Src), 32'd0);
        chk("clr_busy",  32'(Busy),       32'd0);
        chk("clr_shown", 32'(Msg_Shown),  32'd0);
        chk("clr_num",   32'(Number_Sig), 32'h000150);
        quiet_count(12, nbusy);
        chk("clr_pending_empty", 32'(nbusy), 32'd0);

`ifdef SMG_BLINK_EN
        // Blink pattern over one hold
        pulse(3'b001, dat(0, 24'h123456), 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("blink_num", 32'(Number_Sig), (((k / 2) % 2) == 0) ? 32'h123456 : 32'hFFFFFF);
            @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
`endif

        // Reset mid-message drops active and pending
        pulse(3'b010, dat(1, 24'h444444), 1'b0);
        pulse(3'b001, dat(0, 24'h555555), 1'b0);
        #2 RSTn = 1'b0;
        #1;
        chk("mrst_num",  32'(Number_Sig), 32'h0);
        chk("mrst_src",  32'(Active_Src), 32'd0);
        chk("mrst_busy", 32'(Busy),       32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        quiet_count(12, nbusy);
        chk("mrst_pending_empty", 32'(nbusy), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge CLK);
            Idle_Data = 24'($urandom);
            Msg_Data  = {8'($urandom), 32'($urandom), 32'($urandom)};
            for (int b = 0; b < 3; b++) Msg_Req[b] = ($urandom_range(0, 5) == 0);
            Clear = ($urandom_range(0, 39) == 0);
        end
        @(negedge CLK);
        Msg_Req = 3'b000;
        Clear   = 1'b0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smg_display_arbiter.md
# smg_display_arbiter

Shares the single six-digit seven-segment display between a background value and three prioritised message sources in the vending machine, for example price, change and fault. It drives the 24-bit `Number_Sig` word consumed by `smg_interface`. A granted message is held on the display for a fixed time. Lower-priority messages that arrive meanwhile are queued. Higher-priority messages preempt the one on display.

## Interface
- `HOLD_CYCLES`, default 50_000_000: display time of one message, in clock cycles; legal values are 2 and above.
- `BLINK_CYCLES`, default 12_500_000: half-period of the blink, used only when `SMG_BLINK_EN` is defined.
- `BLANK_WORD`, default 24'hFFFFFF: word driven during the blink-off phase.
- `CLK`  in  1: system clock. All logic is on the rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `Idle_Data`  in  24: background value (six BCD digits), shown when no message is active.
- `Msg_Req`  in  3: one request bit per source. Bit 2 is the highest priority. A request is a single-cycle pulse.
- `Msg_Data`  in  72: message words. Source i occupies `[24*i+23:24*i]` and is sampled in the same cycle as its `Msg_Req[i]`.
- `Clear`  in  1: synchronous flush of the active message and all pending messages.
- `Number_Sig`  out  24: registered display word, to `smg_interface`.
- `Active_Src`  out  2: 0 means idle; 1 to 3 means source 0 to 2 is on display.
- `Busy`  out  1: high while in the HOLD state.
- `Msg_Shown`  out  3: one-cycle pulse on bit i when message i starts being displayed.

## Operation
- Two states, IDLE and HOLD.
- Each source owns a pending slot holding a valid bit and a 24-bit word.
- **IDLE:**
  - `Number_Sig` is loaded with `Idle_Data` every cycle.
  - If any request is present, the arbiter grants the highest-indexed `Msg_Req` bit.
  - A grant loads that source's word, sets `Active_Src`, pulses `Msg_Shown`, loads the hold counter with HOLD_CYCLES-1, and moves to HOLD.
  - Other requests arriving in the same cycle are written to their pending slots.
- **HOLD:** each request is handled by comparing its source with the active source.
  - Higher index than the active source: preempts immediately and is granted as in IDLE. The preempted message is discarded, not resumed.
  - Same index as the active source: new word is displayed, counter reloads, and `Msg_Shown` pulses again.
  - Lower index than the active source: written to its pending slot. A second request from the same source overwrites the slot (last writer wins).
- **Counter expiry:** when the counter reaches 0 in HOLD:
  - If any pending slot is valid, the highest valid slot is granted. Its valid bit is cleared, it gets a fresh HOLD_CYCLES, and `Msg_Shown` pulses. The state stays HOLD.
  - If no slot is valid, the state returns to IDLE and `Number_Sig` takes `Idle_Data` on the next edge.
- **Expiry coinciding with a new request:** the new request and the valid pending slots are arbitrated together by index. A new request beats a pending slot of the same index.
- **Clear:** has priority over everything else in its cycle.
  - Clears all pending slots, goes to IDLE, and sets `Active_Src` to 0.
  - Requests in the same cycle are discarded, with no `Msg_Shown` pulse.
- **Reset values:**
  - `Number_Sig`: 24'h000000.
  - `Active_Src`: 0.
  - `Busy`: 0.
  - `Msg_Shown`: 0.
  - Pending slots: empty.
  - Counter: 0.
  - State: IDLE.
  - Blink phase: on.
  - Reset asserted mid-message drops the message and all pending messages.

## Timing
- A request sampled at edge n appears on `Number_Sig`, `Active_Src` and `Msg_Shown` immediately after edge n. Latency is one cycle.
- In IDLE, `Idle_Data` reaches `Number_Sig` after a one-cycle register delay.
- A message with no preemption is visible for exactly HOLD_CYCLES cycles. The following content appears after edge n+HOLD_CYCLES.
- `Msg_Shown` is exactly one cycle wide per grant.
- `Busy` is registered and aligned with `Active_Src` being non-zero.

## Configuration
- `SMG_BLINK_EN` defined:
  - In HOLD, `Number_Sig` alternates between the message word and BLANK_WORD every BLINK_CYCLES.
  - The phase restarts as "on" at every grant.
  - `Idle_Data` never blinks.
- `SMG_BLINK_EN` undefined:
  - The message word is steady for the whole hold.
  - The blink counter and phase logic are not built.

## Test plan
Bench uses HOLD_CYCLES=8, BLINK_CYCLES=2.
- **Background tracking:** reset, then `Idle_Data`=24'h000150 -> one cycle later `Number_Sig`=24'h000150, `Active_Src`=0, `Busy`=0.
- **Single message:** `Msg_Req`=3'b001 with word 24'h000200 -> `Msg_Shown[0]` pulses once; `Number_Sig`=24'h000200 for 8 cycles, then `Idle_Data`.
- **Preemption:** source 0 is active; 3 cycles in, `Msg_Req[2]` with 24'hEEEEEE -> display switches next cycle for 8 full cycles; source 0 is never shown again.
- **Queueing:** source 2 is active; source 1 requests 24'h000050 and later 24'h000060 -> after expiry only 24'h000060 is shown, for 8 cycles, with one `Msg_Shown[1]`.
- **Clear wins:** `Clear` and `Msg_Req`=3'b100 asserted together while HOLD has a pending slot -> next cycle IDLE, `Active_Src`=0, no pulse, pending empty.
- **Blink (with `SMG_BLINK_EN`):** grant 24'h123456 -> `Number_Sig` sequence over 8 cycles is msg,msg,blank,blank,msg,msg,blank,blank.
